// File: rtl/framebuffer_writer_pkg.sv
// Shared renderer geometry plus the pixel record and state type used by the framebuffer writer.
`ifndef FB_DEFINES_SVH
`define FB_DEFINES_SVH
`define X_BITES 8
`define Y_BITES 7
`define COLOR_BITES 3
`define FB_W 160
`define FB_H 120
`define FB_SIZE 19200
`endif

package framebuffer_writer_pkg;

  localparam int unsigned XBits     = `X_BITES;
  localparam int unsigned YBits     = `Y_BITES;
  localparam int unsigned ColorBits = `COLOR_BITES;
  localparam int unsigned PixelBits = XBits + YBits + ColorBits;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StClear = 1'b1
  } fbw_state_e;

  typedef struct packed {
    logic [XBits-1:0]     x;
    logic [YBits-1:0]     y;
    logic [ColorBits-1:0] color;
  } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO buffering plot requests between the pixel producer and the framebuffer port.
module plot_fifo #(
  parameter int unsigned Width = 18,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  // A push into a full FIFO is lost even when a pop frees a slot on the same edge.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Turns a buffered pixel stream into framebuffer writes, with a full-screen fill mode.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned FB_W       = `FB_W,
  parameter int unsigned FB_H       = `FB_H,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [`X_BITES-1:0]     in_x,
  input  logic [`Y_BITES-1:0]     in_y,
  input  logic [`COLOR_BITES-1:0] in_color,
  input  logic                    plot,
  input  logic                    clear,
  input  logic [`COLOR_BITES-1:0] clear_color,
  output logic [14:0]             fb_addr,
  output logic [`COLOR_BITES-1:0] fb_data,
  output logic                    fb_we,
  output logic                    full,
  output logic                    busy,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int unsigned FbSize   = FB_W * FB_H;
  localparam logic [14:0] LastAddr = 15'(FbSize - 1);

  fbw_state_e           state_q, state_d;
  logic [14:0]          clr_addr_q, clr_addr_d;
  logic [ColorBits-1:0] clr_color_q, clr_color_d;
  logic [14:0]          fb_addr_q, fb_addr_d;
  logic [ColorBits-1:0] fb_data_q, fb_data_d;
  logic                 fb_we_q, fb_we_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           drop_q, drop_d;

  logic                 fifo_pop, fifo_empty, fifo_full;
  logic [PixelBits-1:0] fifo_rdata;
  pixel_t               push_pix, pop_pix;
  logic [14:0]          pix_x, pix_y, pix_addr;
  logic                 pix_in_range;

  assign push_pix = '{x: in_x, y: in_y, color: in_color};
  assign pop_pix  = pixel_t'(fifo_rdata);

  plot_fifo #(
    .Width (PixelBits),
    .Depth (FIFO_DEPTH)
  ) u_plot_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .push_i  (plot),
    .pop_i   (fifo_pop),
    .wdata_i (push_pix),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pix_x = 15'(pop_pix.x);
  assign pix_y = 15'(pop_pix.y);

  if (FB_W == 160) begin : g_addr_shift
    // 160 = 128 + 32: two shifted adds instead of a multiplier.
    assign pix_addr = (pix_y << 7) + (pix_y << 5) + pix_x;
  end else begin : g_addr_mul
    assign pix_addr = pix_y * 15'(FB_W) + pix_x;
  end

  assign pix_in_range = (32'(pop_pix.x) < FB_W) && (32'(pop_pix.y) < FB_H);

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    fb_we_d     = 1'b0;
    drop_d      = drop_q;
    ovf_d       = ovf_q | (plot & fifo_full);
    fifo_pop    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (pix_in_range) begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_addr;
            fb_data_d = pop_pix.color;
          end else if (drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
          end
        end
        // A pop on the same edge still writes; the fill starts on the following edge.
        if (clear) begin
          state_d     = StClear;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
        end
      end
      StClear: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_addr_q;
        fb_data_d = clr_color_q;
        if (clr_addr_q == LastAddr) begin
          state_d = StRun;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StRun;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      fb_we_q     <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fb_we_q     <= fb_we_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign full       = fifo_full;
  assign busy       = (state_q == StClear);
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
